// File: rtl/pc_pkg.sv
// Shared types and constants for the PC / branch-redirect stage.
// Holds the FSM state enum, PC step and the next-PC select encoding.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } pc_state_e;

  localparam int          PC_STEP          = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_HOLD   = 2'd1,
    SEL_BRANCH = 2'd2,
    SEL_JUMP   = 2'd3
  } pc_sel_e;

  // Branch beats jump; both beat stall and a not-ready instruction memory.
  function automatic pc_sel_e pc_select(input logic branch, input logic jump,
                                        input logic stall, input logic ready);
    pc_sel_e sel;
    if (branch)      sel = SEL_BRANCH;
    else if (jump)   sel = SEL_JUMP;
    else if (stall)  sel = SEL_HOLD;
    else if (!ready) sel = SEL_HOLD;
    else             sel = SEL_SEQ;
    return sel;
  endfunction

endpackage

// File: rtl/branch_target_adder.sv
// Branch target = PC+4 of the branch plus the pre-shifted offset.
// Purely combinational; the carry out of the top bit is dropped.
module branch_target_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] target
);

  assign target = base + offset;

endmodule

// File: rtl/pc_branch_redirect.sv
// PC stage: holds/advances the fetch PC, redirects on branch/jump, and flushes IF/ID.
// Optional taken-redirect counter enabled by defining BRANCH_STATS_EN.
module pc_branch_redirect
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_PC     = WIDTH'(RESET_PC_DEFAULT),
  parameter int               FLUSH_CYCLES = 1,
  parameter int               STAT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [WIDTH-1:0]  branch_base_i,
  input  logic [WIDTH-1:0]  branch_off_i,
  input  logic              jump_i,
  input  logic [25:0]       jump_idx_i,
  input  logic              imem_ready_i,
  output logic              imem_req_o,
  output logic [WIDTH-1:0]  pc_o,
  output logic [WIDTH-1:0]  pc_plus4_o,
  output logic              flush_o,
  output logic [STAT_W-1:0] taken_cnt_o
);

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  pc_state_e        state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [2:0]       flush_cnt_reg, flush_cnt_next;
  logic             flush_reg, flush_next;
  logic             req_reg, req_next;
  logic [WIDTH-1:0] branch_target, jump_target;
  logic             active, redirect;
  pc_sel_e          sel;

  branch_target_adder #(.WIDTH(WIDTH)) u_target_adder (
    .base   (branch_base_i),
    .offset (branch_off_i),
    .target (branch_target)
  );

  assign pc_plus4_o  = pc_reg + WIDTH'(PC_STEP);
  assign jump_target = {pc_plus4_o[WIDTH-1:28], jump_idx_i, 2'b00};
  assign active      = (state_reg != BOOT);
  assign sel         = pc_select(branch_i, jump_i, stall_i, imem_ready_i);
  // A redirect is honoured regardless of stall/ready, but never while booting.
  assign redirect    = active && (branch_i || jump_i);

  always_comb begin
    pc_next = pc_reg;
    if (active) begin
      case (sel)
        SEL_BRANCH: pc_next = branch_target;
        SEL_JUMP:   pc_next = jump_target;
        SEL_SEQ:    pc_next = pc_plus4_o;
        default:    pc_next = pc_reg;
      endcase
    end
    pc_next[1:0] = 2'b00;
  end

  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    case (state_reg)
      BOOT: state_next = RUN;
      RUN: begin
        if (redirect) begin
          state_next     = FLUSH;
          flush_cnt_next = '0;
        end
      end
      FLUSH: begin
        if (redirect) begin
          flush_cnt_next = '0;
        end else if (flush_cnt_reg == FLUSH_LAST) begin
          state_next     = RUN;
          flush_cnt_next = '0;
        end else begin
          flush_cnt_next = flush_cnt_reg + 3'd1;
        end
      end
      default: state_next = BOOT;
    endcase
    flush_next = (state_next == FLUSH);
    req_next   = (state_next != BOOT);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg     <= BOOT;
      pc_reg        <= RESET_PC;
      flush_cnt_reg <= '0;
      flush_reg     <= 1'b0;
      req_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      flush_cnt_reg <= flush_cnt_next;
      flush_reg     <= flush_next;
      req_reg       <= req_next;
    end
  end

  assign pc_o       = pc_reg;
  assign flush_o    = flush_reg;
  assign imem_req_o = req_reg;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] taken_cnt_reg;

  // Saturating count of accepted redirects; a branch+jump pair counts once.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      taken_cnt_reg <= '0;
    end else if (redirect && (taken_cnt_reg != {STAT_W{1'b1}})) begin
      taken_cnt_reg <= taken_cnt_reg + STAT_W'(1);
    end
  end

  assign taken_cnt_o = taken_cnt_reg;
`else
  assign taken_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pc_branch_redirect.sv
// Bench for pc_branch_redirect: a FLUSH_CYCLES=1 instance and a FLUSH_CYCLES=3/STAT_W=2
// instance share one stimulus table; expectations queue in a scoreboard.
`timescale 1ns/1ps
module tb_pc_branch_redirect;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0, branch_i = 1'b0, jump_i = 1'b0, imem_ready_i = 1'b0;
  logic [31:0] branch_base_i = '0, branch_off_i = '0;
  logic [25:0] jump_idx_i = '0;

  logic        req_a, req_b, flush_a, flush_b;
  logic [31:0] pc_a, pc_b, pc4_a, pc4_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  pc_branch_redirect #(.WIDTH(32), .FLUSH_CYCLES(1), .STAT_W(16)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .branch_i(branch_i),
    .branch_base_i(branch_base_i), .branch_off_i(branch_off_i), .jump_i(jump_i),
    .jump_idx_i(jump_idx_i), .imem_ready_i(imem_ready_i), .imem_req_o(req_a),
    .pc_o(pc_a), .pc_plus4_o(pc4_a), .flush_o(flush_a), .taken_cnt_o(cnt_a)
  );

  pc_branch_redirect #(.WIDTH(32), .FLUSH_CYCLES(3), .STAT_W(2)) u_dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .branch_i(branch_i),
    .branch_base_i(branch_base_i), .branch_off_i(branch_off_i), .jump_i(jump_i),
    .jump_idx_i(jump_idx_i), .imem_ready_i(imem_ready_i), .imem_req_o(req_b),
    .pc_o(pc_b), .pc_plus4_o(pc4_b), .flush_o(flush_b), .taken_cnt_o(cnt_b)
  );

  typedef struct {
    logic        st, br;
    logic [31:0] base, off;
    logic        jp;
    logic [25:0] idx;
    logic        rdy;
    logic [31:0] pc;
    logic        req, fl, fl3;
    int          n;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        req, fl, fl3;
    int          n;
  } exp_t;

  vec_t vecs[24];
  exp_t sb_q[$];

  function automatic vec_t mkv(logic st, logic br, logic [31:0] base, logic [31:0] off,
                               logic jp, logic [25:0] idx, logic rdy, logic [31:0] pc,
                               logic req, logic fl, logic fl3, int n);
    vec_t v;
    v.st = st; v.br = br; v.base = base; v.off = off; v.jp = jp; v.idx = idx; v.rdy = rdy;
    v.pc = pc; v.req = req; v.fl = fl; v.fl3 = fl3; v.n = n;
    return v;
  endfunction

  function automatic logic [31:0] exp_cnt(int n, int w);
`ifdef BRANCH_STATS_EN
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? 32'(mx) : 32'(n);
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one vector right after an edge, then compare right after the next edge.
  task automatic apply(vec_t v, int id);
    exp_t e;
    exp_t g;
    stall_i = v.st; branch_i = v.br; branch_base_i = v.base; branch_off_i = v.off;
    jump_i = v.jp; jump_idx_i = v.idx; imem_ready_i = v.rdy;
    e.id = id; e.pc = v.pc; e.req = v.req; e.fl = v.fl; e.fl3 = v.fl3; e.n = v.n;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got empty queue expected entry %0d", id);
    end else begin
      g = sb_q.pop_front();
      chk($sformatf("v%0d pc", g.id), pc_a, g.pc);
      chk($sformatf("v%0d pc_fc3", g.id), pc_b, g.pc);
      chk($sformatf("v%0d pc_plus4", g.id), pc4_a, g.pc + 32'd4);
      chk($sformatf("v%0d imem_req", g.id), {31'd0, req_a}, {31'd0, g.req});
      chk($sformatf("v%0d flush", g.id), {31'd0, flush_a}, {31'd0, g.fl});
      chk($sformatf("v%0d flush_fc3", g.id), {31'd0, flush_b}, {31'd0, g.fl3});
      chk($sformatf("v%0d taken_cnt", g.id), {16'd0, cnt_a}, exp_cnt(g.n, 16));
      chk($sformatf("v%0d taken_cnt_w2", g.id), {30'd0, cnt_b}, exp_cnt(g.n, 2));
      $display("vec %0d: pc=%h req=%b flush=%b flush3=%b cnt=%0d cnt2=%0d",
               g.id, pc_a, req_a, flush_a, flush_b, cnt_a, cnt_b);
    end
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, " pc"}, pc_a, 32'h0);
    chk({tag, " pc_fc3"}, pc_b, 32'h0);
    chk({tag, " imem_req"}, {31'd0, req_a}, 32'd0);
    chk({tag, " flush"}, {31'd0, flush_a}, 32'd0);
    chk({tag, " flush_fc3"}, {31'd0, flush_b}, 32'd0);
    chk({tag, " taken_cnt"}, {16'd0, cnt_a}, 32'd0);
    chk({tag, " taken_cnt_w2"}, {30'd0, cnt_b}, 32'd0);
  endtask

  initial begin
    //            st br base          off           jp idx          rdy pc            req fl fl3 n
    vecs[0]  = mkv(0, 1, 32'h0000_0100, 32'h0,        0, 26'h0,       1, 32'h0000_0000, 1, 0, 0, 0);
    vecs[1]  = mkv(0, 0, 32'h0,         32'h0,        0, 26'h0,       1, 32'h0000_0004, 1, 0, 0, 0);
    vecs[2]  = mkv(0, 0, 32'h0,         32'h0,        0, 26'h0,       1, 32'h0000_0008, 1, 0, 0, 0);
    vecs[3]  = mkv(0, 1, 32'h0000_0010, 32'hFFFF_FFF0, 0, 26'h0,      1, 32'h0000_0000, 1, 1, 1, 1);
    vecs[4]  = mkv(0, 0, 32'h0,         32'h0,        0, 26'h0,       1, 32'h0000_0004, 1, 0, 1, 1);
    vecs[5]  = mkv(0, 0, 32'h0,         32'h0,        0, 26'h0,       1, 32'h0000_0008, 1, 0, 1, 1);
    vecs[6]  = mkv(0, 0, 32'h0,         32'h0,        0, 26'h0,       1, 32'h0000_000C, 1, 0, 0, 1);
    vecs[7]  = mkv(0, 1, 32'h1000_0000, 32'h0,        0, 26'h0,       1, 32'h1000_0000, 1, 1, 1, 2);
    vecs[8]  = mkv(0, 0, 32'h0,         32'h0,        1, 26'h0000040, 1, 32'h1000_0100, 1, 1, 1, 3);
    vecs[9]  = mkv(0, 1, 32'h2000_0000, 32'h0000_0040, 1, 26'h3FFFFFF, 1, 32'h2000_0040, 1, 1, 1, 4);
    vecs[10] = mkv(0, 0, 32'h0,         32'h0,        0, 26'h0,       1, 32'h2000_0044, 1, 0, 1, 4);
    vecs[11] = mkv(0, 0, 32'h0,         32'h0,        0, 26'h0,       1, 32'h2000_0048, 1, 0, 1, 4);
    vecs[12] = mkv(0, 0, 32'h0,         32'h0,        0, 26'h0,       1, 32'h2000_004C, 1, 0, 0, 4);
    vecs[13] = mkv(1, 0, 32'h0,         32'h0,        0, 26'h0,       1, 32'h2000_004C, 1, 0, 0, 4);
    vecs[14] = mkv(1, 0, 32'h0,         32'h0,        0, 26'h0,       1, 32'h2000_004C, 1, 0, 0, 4);
    vecs[15] = mkv(1, 0, 32'h0,         32'h0,        0, 26'h0,       1, 32'h2000_004C, 1, 0, 0, 4);
    vecs[16] = mkv(0, 0, 32'h0,         32'h0,        0, 26'h0,       0, 32'h2000_004C, 1, 0, 0, 4);
    vecs[17] = mkv(0, 0, 32'h0,         32'h0,        0, 26'h0,       0, 32'h2000_004C, 1, 0, 0, 4);
    vecs[18] = mkv(1, 1, 32'h0000_0040, 32'h0000_0008, 0, 26'h0,      0, 32'h0000_0048, 1, 1, 1, 5);
    vecs[19] = mkv(0, 1, 32'hFFFF_FFF0, 32'h0000_000C, 0, 26'h0,      1, 32'hFFFF_FFFC, 1, 1, 1, 6);
    vecs[20] = mkv(0, 0, 32'h0,         32'h0,        0, 26'h0,       1, 32'h0000_0000, 1, 0, 1, 6);
    vecs[21] = mkv(0, 0, 32'h0,         32'h0,        0, 26'h0,       1, 32'h0000_0004, 1, 0, 1, 6);
    vecs[22] = mkv(0, 0, 32'h0,         32'h0,        0, 26'h0,       1, 32'h0000_0008, 1, 0, 0, 6);
    vecs[23] = mkv(0, 1, 32'hFFFF_FFF0, 32'h0000_0020, 0, 26'h0,      1, 32'h0000_0010, 1, 1, 1, 7);

    // Power-up reset
    #1 rst_i = 1'b0;
    #1 chk_reset_state("reset");
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    chk("boot imem_req", {31'd0, req_a}, 32'd0);

    for (int i = 0; i < 24; i++) apply(vecs[i], i);

    // Asynchronous reset in the middle of a flush window
    #2 rst_i = 1'b0;
    #1 chk_reset_state("midflush_reset");
    @(posedge clk_i);
    #1;
    chk_reset_state("reset_held");
    rst_i = 1'b1;

    // Five back-to-back redirects after reset: the 2-bit counter saturates at 3
    apply(mkv(0, 1, 32'h0000_0300, 32'h0, 0, 26'h0, 1, 32'h0, 1, 0, 0, 0), 100);
    for (int k = 1; k <= 5; k++) begin
      apply(mkv(0, 1, 32'(k * 256), 32'h0, 0, 26'h0, 1, 32'(k * 256), 1, 1, 1, k), 100 + k);
    end
    apply(mkv(0, 0, 32'h0, 32'h0, 0, 26'h0, 1, 32'h0000_0504, 1, 0, 1, 5), 106);
    apply(mkv(0, 0, 32'h0, 32'h0, 0, 26'h0, 1, 32'h0000_0508, 1, 0, 1, 5), 107);
    apply(mkv(0, 0, 32'h0, 32'h0, 0, 26'h0, 1, 32'h0000_050C, 1, 0, 0, 5), 108);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
